// File: rtl/multi_timer.sv
// Multi-channel down-counting timer with one-shot and auto-reload modes.
// Optional tick prescaler is compiled in when TIMER_PRESCALER_EN is defined.
module multi_timer #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 4
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              load,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] load_chan,
  input  logic [WIDTH-1:0]                                  cycles,
  input  logic                                              periodic,
  input  logic [CHANNELS-1:0]                               stop,
  output logic [CHANNELS-1:0]                               busy,
  output logic [CHANNELS-1:0]                               done
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  if (WIDTH < 2) begin : g_bad_width
    $error("multi_timer: WIDTH must be at least 2");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("multi_timer: CHANNELS must be at least 1");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("multi_timer: PRESCALE must be at least 1");
  end

  logic tick;

`ifdef TIMER_PRESCALER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] prescale_cnt;

  // Free-running divider shared by all channels; loads and stops bypass it.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_cnt <= '0;
    end else if (prescale_cnt == PW'(PRESCALE - 1)) begin
      prescale_cnt <= '0;
    end else begin
      prescale_cnt <= prescale_cnt + PW'(1);
    end
  end

  assign tick = (prescale_cnt == PW'(PRESCALE - 1));
`else
  assign tick = 1'b1;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] reload;
    logic             mode;
    logic             done_r;
    logic             hit;

    // Equality with an in-range index already rejects out-of-range selects.
    assign hit = load && (load_chan == CW'(i));

    always_ff @(posedge clk) begin
      if (reset) begin
        counter <= '0;
        reload  <= '0;
        mode    <= 1'b0;
        done_r  <= 1'b0;
      end else begin
        done_r <= 1'b0;
        if (hit) begin
          if (cycles != '0) begin
            counter <= cycles;
            reload  <= cycles;
            mode    <= periodic;
          end else begin
            counter <= '0;
            mode    <= 1'b0;
          end
        end else if (stop[i]) begin
          counter <= '0;
          mode    <= 1'b0;
        end else if (tick && (counter != '0)) begin
          if (counter == WIDTH'(1)) begin
            done_r  <= 1'b1;
            counter <= mode ? reload : '0;
          end else begin
            counter <= counter - WIDTH'(1);
          end
        end
      end
    end

    assign busy[i] = (counter != '0);
    assign done[i] = done_r;
  end

endmodule
